// File: rtl/toggle_pkg.sv
// Shared types and defaults for the toggle pulse generator and the flip-flop stage bench.
package toggle_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StGap,
    StPulse,
    StDone
  } tpg_state_e;

  localparam int unsigned CNT_W_DEFAULT = 8;
  localparam int unsigned GAP_W_DEFAULT = 8;

endpackage

// File: rtl/tpg_down_counter.sv
// Loadable saturating down counter with a zero flag; never decrements below zero.
module tpg_down_counter #(
  parameter int unsigned W = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         dec,
  output logic [W-1:0] value,
  output logic         zero
);

  logic [W-1:0] value_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      value_q <= '0;
    end else if (load) begin
      value_q <= load_val;
    end else if (dec && (value_q != '0)) begin
      value_q <= value_q - W'(1);
    end
  end

  assign value = value_q;
  assign zero  = (value_q == '0);

endmodule

// File: rtl/toggle_pulse_gen.sv
// Command-driven sequencer issuing spaced one-cycle tin pulses to the toggle flip-flop stage,
// with completion pulse and expected toggle parity.
module toggle_pulse_gen
  import toggle_pkg::*;
#(
  parameter int unsigned CNT_W = CNT_W_DEFAULT,
  parameter int unsigned GAP_W = GAP_W_DEFAULT
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [CNT_W-1:0] cmd_count,
  input  logic [GAP_W-1:0] cmd_gap,
  input  logic             abort,
  output logic             tin,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] pulses_left,
  output logic             q_exp
);

  tpg_state_e state_q, state_d;

  logic [GAP_W-1:0] gap_q;
  logic             tin_q, busy_q, done_q, q_q;

  logic             accept;
  logic             gap_load, gap_dec, gap_zero;
  logic [GAP_W-1:0] gap_load_val;
  logic [GAP_W-1:0] gap_cnt;
  logic             pl_load, pl_dec, pl_zero;
  logic             q_toggle;

  assign cmd_ready = (state_q == StIdle) && !abort;
  assign accept    = cmd_valid && cmd_ready;

  always_comb begin
    state_d      = state_q;
    gap_load     = 1'b0;
    gap_load_val = gap_q;
    gap_dec      = 1'b0;
    pl_load      = 1'b0;
    pl_dec       = 1'b0;
    q_toggle     = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (accept) begin
          state_d      = StGap;
          gap_load     = 1'b1;
          gap_load_val = cmd_gap;
          pl_load      = 1'b1;
        end
      end
      StGap: begin
        // pl_zero here only occurs for a zero-count command.
        if (abort || pl_zero) begin
          state_d = StDone;
        end else if (gap_zero) begin
          state_d  = StPulse;
          pl_dec   = 1'b1;
          q_toggle = 1'b1;
        end else begin
          gap_dec = 1'b1;
        end
      end
      StPulse: begin
        if (abort || pl_zero) begin
          state_d = StDone;
        end else if (gap_q == '0) begin
          pl_dec   = 1'b1;
          q_toggle = 1'b1;
        end else begin
          // The pulse cycle itself is not a gap cycle, so reload one short.
          state_d      = StGap;
          gap_load     = 1'b1;
          gap_load_val = gap_q - GAP_W'(1);
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIdle;
      gap_q   <= '0;
      tin_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      q_q     <= 1'b0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        gap_q <= cmd_gap;
      end
      tin_q  <= (state_d == StPulse);
      busy_q <= (state_d != StIdle);
      done_q <= (state_d == StDone);
      if (q_toggle) begin
        q_q <= ~q_q;
      end
    end
  end

  tpg_down_counter #(
    .W(GAP_W)
  ) u_gap_cnt (
    .clk     (clk),
    .reset   (reset),
    .load    (gap_load),
    .load_val(gap_load_val),
    .dec     (gap_dec),
    .value   (gap_cnt),
    .zero    (gap_zero)
  );

  tpg_down_counter #(
    .W(CNT_W)
  ) u_pulse_cnt (
    .clk     (clk),
    .reset   (reset),
    .load    (pl_load),
    .load_val(cmd_count),
    .dec     (pl_dec),
    .value   (pulses_left),
    .zero    (pl_zero)
  );

  assign tin   = tin_q;
  assign busy  = busy_q;
  assign done  = done_q;
  assign q_exp = q_q;

endmodule

// File: tb/tb_toggle_pulse_gen.sv
// Self-checking bench for toggle_pulse_gen: directed vector table, back-to-back sequence and
// randomized traffic against a timing-formula reference model.
module tb_toggle_pulse_gen;

  localparam int unsigned CNT_W = 8;
  localparam int unsigned GAP_W = 8;

  logic             clk;
  logic             reset;
  logic             cmd_valid;
  logic             cmd_ready;
  logic [CNT_W-1:0] cmd_count;
  logic [GAP_W-1:0] cmd_gap;
  logic             abort;
  logic             tin;
  logic             busy;
  logic             done;
  logic [CNT_W-1:0] pulses_left;
  logic             q_exp;

  toggle_pulse_gen #(
    .CNT_W(CNT_W),
    .GAP_W(GAP_W)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_count  (cmd_count),
    .cmd_gap    (cmd_gap),
    .abort      (abort),
    .tin        (tin),
    .busy       (busy),
    .done       (done),
    .pulses_left(pulses_left),
    .q_exp      (q_exp)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0d, expected %0d", name, $time, act, exp);
    end
  endtask

  // Reference model: a command accepted at edge 0 pulses at edges k*(G+1), k=1..count,
  // completes at edge count*(G+1)+1 (or at the abort edge), and is idle one edge later.
  bit m_idle = 1'b1;
  int m_t, m_cnt, m_gp, m_end, m_issued;
  bit m_tin, m_busy, m_done, m_q;

  task automatic model_edge(input bit r, input bit v, input int c, input int g, input bit a);
    if (r) begin
      m_idle = 1; m_tin = 0; m_busy = 0; m_done = 0; m_q = 0; m_cnt = 0; m_issued = 0;
    end else if (m_idle) begin
      m_tin = 0; m_done = 0; m_busy = 0;
      if (v && !a) begin
        m_idle = 0; m_t = 0; m_cnt = c; m_gp = g; m_issued = 0;
        m_end = c * (g + 1) + 1; m_busy = 1;
      end
    end else begin
      m_t++;
      if (a && m_t < m_end) m_end = m_t;
      if (m_t == m_end) begin
        m_done = 1; m_tin = 0; m_busy = 1;
      end else if (m_t > m_end) begin
        m_idle = 1; m_done = 0; m_tin = 0; m_busy = 0;
      end else begin
        m_done = 0; m_busy = 1;
        m_tin = ((m_t % (m_gp + 1)) == 0);
        if (m_tin) begin
          m_issued++;
          m_q = ~m_q;
        end
      end
    end
  endtask

  // One clock: drive inputs, check cmd_ready, clock, then check all registered outputs.
  task automatic step(input bit r, input bit v, input int c, input int g, input bit a);
    reset = r; cmd_valid = v; cmd_count = CNT_W'(c); cmd_gap = GAP_W'(g); abort = a;
    #1;
    check("cmd_ready", int'(cmd_ready), int'(m_idle && !a));
    @(posedge clk);
    model_edge(r, v, c, g, a);
    #1;
    check("tin", int'(tin), int'(m_tin));
    check("busy", int'(busy), int'(m_busy));
    check("done", int'(done), int'(m_done));
    check("pulses_left", int'(pulses_left), m_cnt - m_issued);
    check("q_exp", int'(q_exp), int'(m_q));
  endtask

  typedef struct {
    int          cnt;
    int          gap;
    int          abort_at;
    int          reset_at;
    logic [31:0] tin_mask;
    int          done_at;
    int          pl_end;
    int          q_end;
    int          len;
  } vec_t;

  vec_t vecs[5];
  int   busy_log[6];
  int   tin_log[6];

  initial begin
    vecs[0] = '{cnt: 3, gap: 2, abort_at: 0, reset_at: 0, tin_mask: 32'h248, done_at: 10,
                pl_end: 0, q_end: 1, len: 11};
    vecs[1] = '{cnt: 4, gap: 0, abort_at: 0, reset_at: 0, tin_mask: 32'h1e, done_at: 5,
                pl_end: 0, q_end: 0, len: 6};
    vecs[2] = '{cnt: 0, gap: 7, abort_at: 0, reset_at: 0, tin_mask: 32'h0, done_at: 1,
                pl_end: 0, q_end: 0, len: 2};
    vecs[3] = '{cnt: 5, gap: 1, abort_at: 5, reset_at: 0, tin_mask: 32'h14, done_at: 5,
                pl_end: 3, q_end: 0, len: 6};
    vecs[4] = '{cnt: 6, gap: 3, abort_at: 0, reset_at: 6, tin_mask: 32'h10, done_at: 0,
                pl_end: 0, q_end: 0, len: 7};

    // Reset values.
    for (int i = 0; i < 3; i++) step(1, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0);
    check("rst_tin", int'(tin), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_done", int'(done), 0);
    check("rst_pl", int'(pulses_left), 0);
    check("rst_q", int'(q_exp), 0);
    check("rst_ready", int'(cmd_ready), 1);

    // Directed vector table, each row from a fresh reset.
    foreach (vecs[i]) begin
      for (int k = 0; k < 3; k++) step(1, 0, 0, 0, 0);
      step(0, 1, vecs[i].cnt, vecs[i].gap, 0);
      check($sformatf("v%0d_accept_busy", i), int'(busy), 1);
      for (int t = 1; t <= vecs[i].len; t++) begin
        step(t == vecs[i].reset_at, 0, 0, 0, t == vecs[i].abort_at);
        check($sformatf("v%0d_tin_e%0d", i, t), int'(tin), int'(vecs[i].tin_mask[t]));
        check($sformatf("v%0d_done_e%0d", i, t), int'(done), int'(t == vecs[i].done_at));
      end
      check($sformatf("v%0d_pl_end", i), int'(pulses_left), vecs[i].pl_end);
      check($sformatf("v%0d_q_end", i), int'(q_exp), vecs[i].q_end);
      check($sformatf("v%0d_busy_end", i), int'(busy), 0);
      check($sformatf("v%0d_ready_end", i), int'(cmd_ready), 1);
    end

    // Back-to-back with cmd_valid held: count=1, G=0 re-accepts at edge 4.
    for (int k = 0; k < 3; k++) step(1, 0, 0, 0, 0);
    for (int e = 0; e < 6; e++) begin
      step(0, 1, 1, 0, 0);
      busy_log[e] = int'(busy);
      tin_log[e]  = int'(tin);
    end
    check("b2b_busy_e0", busy_log[0], 1);
    check("b2b_tin_e1", tin_log[1], 1);
    check("b2b_busy_e3", busy_log[3], 0);
    check("b2b_busy_e4", busy_log[4], 1);
    check("b2b_tin_e4", tin_log[4], 0);
    check("b2b_tin_e5", tin_log[5], 1);

    // Abort and reset in idle must not start anything; reset mid-command then immediate accept.
    step(0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0);
    step(0, 1, 2, 0, 1);
    check("idle_abort_blocks", int'(busy), 0);
    step(0, 1, 6, 3, 0);
    for (int k = 0; k < 5; k++) step(0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0);
    check("midreset_done", int'(done), 0);
    step(0, 1, 2, 1, 0);
    check("post_reset_accept", int'(busy), 1);

    // Randomized traffic against the model.
    for (int n = 0; n < 3000; n++) begin
      step(($urandom_range(0, 99) == 0), ($urandom_range(0, 1) == 1), $urandom_range(0, 6),
           $urandom_range(0, 3), ($urandom_range(0, 15) == 0));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/toggle_pulse_gen.md
Name: toggle_pulse_gen

Overview:
Command-driven toggle-enable sequencer. It sits directly upstream of the team's toggle flip-flop stage and drives that stage's tin input. It accepts a command of (pulse count, gap length) over a valid/ready handshake. It then emits exactly that many one-cycle tin pulses, spaced by the programmed gap, and signals completion. It also tracks the expected toggle parity so downstream checkers can compare against the flip-flop's q.

Parameters:
CNT_W, 8, width of pulse count; max pulses per command = 2^CNT_W-1
GAP_W, 8, width of gap length; max gap = 2^GAP_W-1 idle cycles

Ports:
clk  in  1  clock; block updates on posedge (flip-flop stage samples tin on negedge, so tin is stable half a cycle before use)
reset  in  1  synchronous, active-high
cmd_valid  in  1  command present
cmd_ready  out  1  command accepted when valid&&ready at a posedge
cmd_count  in  CNT_W  number of tin pulses
cmd_gap  in  GAP_W  low cycles between pulses (G)
abort  in  1  terminate current command
tin  out  1  toggle enable to flip-flop stage
busy  out  1  command in progress
done  out  1  one-cycle completion pulse
pulses_left  out  CNT_W  pulses still to be issued
q_exp  out  1  expected flip-flop q: toggles on every tin pulse

Behaviour:
- Reset (reset=1 at posedge, any state):
  - state IDLE; tin=0, busy=0, done=0, pulses_left=0, q_exp=0.
  - No done pulse is generated by reset.
  - Reset mid-command discards the command within one edge.
- States: IDLE, GAP, PULSE, DONE.
- cmd_ready is combinational: (state==IDLE) && !abort. All other outputs are registered.
- Timing, with edges numbered from the accept edge = 0:
  - tin is high in the cycle after edges k*(G+1), for k=1..count.
  - G=0: tin is high continuously for count cycles.
  - done is high in the cycle after edge count*(G+1)+1.
  - State is IDLE (cmd_ready=1) after the following edge.
- Accept:
  - Latch count and gap; pulses_left=count; busy=1; go GAP, gap counter loaded with G.
  - count=0: go straight to DONE; no tin pulse; done high after edge 1.
- GAP: gap counter decrements each cycle; at 0, the next state is PULSE.
- PULSE:
  - tin=1 for one cycle; pulses_left decrements; q_exp inverts.
  - pulses_left reaching 0 -> DONE; else reload gap and go GAP (or stay in PULSE if G=0).
- DONE:
  - done=1 for exactly one cycle; busy stays 1; tin=0; next state IDLE.
  - busy falls in the same cycle cmd_ready rises.
- abort:
  - Sampled at posedge in GAP or PULSE: next cycle state DONE, tin=0, done=1.
  - pulses_left holds the unissued count; pulses already driven stand.
  - abort in IDLE or DONE is ignored, except that it blocks acceptance in IDLE.
- Back-to-back: with cmd_valid held high, the next command is accepted on the first edge after returning to IDLE. No overlap with DONE.
- Arithmetic: counters are unsigned and never wrap. pulses_left never goes below 0; gap counter never goes below 0.
- q_exp: cleared only by reset; it persists across commands.

Decomposition:
- Package toggle_pkg:
  - state enum {IDLE, GAP, PULSE, DONE};
  - default CNT_W/GAP_W constants;
  - shared by the flip-flop stage bench.
- One sub-module: tpg_down_counter (parameterised width; load, decrement-enable, zero flag). Instantiated twice, for the gap counter and for pulses_left.

Test Plan:
- reset=1 for 3 edges, then 0 -> tin=0, busy=0, done=0, pulses_left=0, q_exp=0, cmd_ready=1.
- count=3, G=2 accepted at edge 0 -> tin high after edges 3, 6, 9 only; done after edge 10; cmd_ready=1 after edge 11; q_exp=1.
- count=4, G=0 -> tin high after edges 1-4 continuously; done after edge 5; q_exp=0.
- count=0, G=7 -> no tin; done after edge 1; IDLE after edge 2.
- count=5, G=1, abort=1 at edge 5 -> tin after edges 2, 4 only; done after edge 5; pulses_left=3; q_exp=0.
- count=6, G=3, reset at edge 6 -> tin low, busy=0, done never pulses; new command accepted immediately after.
